// File: rtl/pc_ctrl_pkg.sv
// Shared types and constants for the fetch PC controller.
// Holds the FSM state encoding, PC width/increment and the next-PC event codes.
package pc_ctrl_pkg;

    localparam int PC_W = 16;
    localparam logic [PC_W-1:0] PC_INC = 16'd2;

    typedef enum logic [1:0] {
        ST_RUN    = 2'b00,
        ST_EXC    = 2'b01,
        ST_HALTED = 2'b10
    } state_t;

    typedef enum logic [2:0] {
        EV_SEQ   = 3'd0,
        EV_REDIR = 3'd1,
        EV_HALT  = 3'd2,
        EV_ILL   = 3'd3,
        EV_RTI   = 3'd4,
        EV_JMP   = 3'd5
    } event_t;

endpackage

// File: rtl/pc_next_mux.sv
// Combinational next-PC select: picks the highest-priority pending event and its target PC.
// Zero latency; has no flow control of its own (the caller gates it with the stall).
module pc_next_mux
    import pc_ctrl_pkg::*;
(
    input  logic [PC_W-1:0] pc,
    input  logic [PC_W-1:0] pc_ifid,
    input  logic [PC_W-1:0] epc,
    input  logic            dec_ok,
    input  logic            halt,
    input  logic            illegal_op,
    input  logic            return_execution,
    input  logic            jmp_displacement,
    input  logic [PC_W-1:0] jmp_disp,
    input  logic            redirect_valid,
    input  logic [PC_W-1:0] redirect_target,
    output event_t          ev,
    output logic [PC_W-1:0] pc_next
);

    always_comb begin
        ev      = EV_SEQ;
        pc_next = pc + PC_INC;
        // Execute redirects outrank decode because they are older in program order.
        if (redirect_valid) begin
            ev      = EV_REDIR;
            pc_next = redirect_target;
        end else if (dec_ok && halt) begin
            ev      = EV_HALT;
            pc_next = pc;
        end else if (dec_ok && illegal_op) begin
            ev      = EV_ILL;
            pc_next = pc;
        end else if (dec_ok && return_execution) begin
            ev      = EV_RTI;
            pc_next = epc;
        end else if (dec_ok && jmp_displacement) begin
            ev      = EV_JMP;
            pc_next = pc_ifid + PC_INC + jmp_disp;
        end
    end

endmodule

// File: rtl/pc_ctrl.sv
// Fetch PC controller: RUN/EXC/HALTED FSM, PC/EPC registers, IF/ID flush generation.
// One-cycle event-to-PC latency (EXC vector two); stall_p1 freezes all state. Macro PC_CTRL_DFAULT_EN halts on double fault.
module pc_ctrl
    import pc_ctrl_pkg::*;
#(
    parameter logic [15:0] RESET_PC   = 16'h0000,
    parameter logic [15:0] EXC_VECTOR = 16'h0002
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_p1,
    input  logic        inst_valid_idif_p1,
    input  logic        halt_idif_p1,
    input  logic        illegal_op_idif_p1,
    input  logic        return_execution_idif_p1,
    input  logic        jmp_displacement_idif_p1,
    input  logic [15:0] jmp_displacement_value_idif_p1,
    input  logic        redirect_valid_ixif_p1,
    input  logic [15:0] redirect_target_ixif_p1,
    output logic [15:0] pc_p1,
    output logic [15:0] pc_ifid_p1,
    output logic [15:0] epc_p1,
    output logic        fetch_en_p1,
    output logic        flush_ifid_p1,
    output logic        in_exc_p1,
    output logic [1:0]  state_p1
);

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d, pc_ifid_q, pc_ifid_d, epc_q, epc_d;
    logic            in_exc_q, in_exc_d, flush_q, flush_d;
    logic            dec_ok;
    event_t          ev;
    logic [PC_W-1:0] pc_next;

    // The slot behind a flush is a wrong-path instruction, so its flags are dropped.
    assign dec_ok = inst_valid_idif_p1 & ~flush_q;

    pc_next_mux u_pc_next_mux (
        .pc               (pc_q),
        .pc_ifid          (pc_ifid_q),
        .epc              (epc_q),
        .dec_ok           (dec_ok),
        .halt             (halt_idif_p1),
        .illegal_op       (illegal_op_idif_p1),
        .return_execution (return_execution_idif_p1),
        .jmp_displacement (jmp_displacement_idif_p1),
        .jmp_disp         (jmp_displacement_value_idif_p1),
        .redirect_valid   (redirect_valid_ixif_p1),
        .redirect_target  (redirect_target_ixif_p1),
        .ev               (ev),
        .pc_next          (pc_next)
    );

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        pc_ifid_d = pc_ifid_q;
        epc_d     = epc_q;
        in_exc_d  = in_exc_q;
        flush_d   = flush_q;
        if (!stall_p1) begin
            flush_d = 1'b0;
            unique case (state_q)
                ST_RUN: begin
                    case (ev)
                        EV_SEQ: begin
                            pc_d      = pc_next;
                            pc_ifid_d = pc_q;
                        end
                        EV_REDIR, EV_JMP: begin
                            pc_d      = pc_next;
                            pc_ifid_d = pc_q;
                            flush_d   = 1'b1;
                        end
                        EV_HALT: state_d = ST_HALTED;
                        EV_ILL: begin
`ifdef PC_CTRL_DFAULT_EN
                            if (in_exc_q) begin
                                state_d = ST_HALTED;
                            end else begin
                                epc_d    = pc_ifid_q + PC_INC;
                                in_exc_d = 1'b1;
                                state_d  = ST_EXC;
                                flush_d  = 1'b1;
                            end
`else
                            epc_d    = pc_ifid_q + PC_INC;
                            in_exc_d = 1'b1;
                            state_d  = ST_EXC;
                            flush_d  = 1'b1;
`endif
                        end
                        EV_RTI: begin
                            pc_d      = pc_next;
                            pc_ifid_d = pc_q;
                            in_exc_d  = 1'b0;
                            flush_d   = 1'b1;
                        end
                        default: ;
                    endcase
                end
                ST_EXC: begin
                    pc_d    = EXC_VECTOR;
                    state_d = ST_RUN;
                    flush_d = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_RUN;
            pc_q      <= RESET_PC;
            pc_ifid_q <= RESET_PC;
            epc_q     <= '0;
            in_exc_q  <= 1'b0;
            flush_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            pc_ifid_q <= pc_ifid_d;
            epc_q     <= epc_d;
            in_exc_q  <= in_exc_d;
            flush_q   <= flush_d;
        end
    end

    assign pc_p1         = pc_q;
    assign pc_ifid_p1    = pc_ifid_q;
    assign epc_p1        = epc_q;
    assign in_exc_p1     = in_exc_q;
    assign state_p1      = state_q;
    assign fetch_en_p1   = (state_q == ST_RUN);
    assign flush_ifid_p1 = rst | (flush_q & ~stall_p1);

endmodule

// File: tb/tb_pc_ctrl.sv
// Directed-vector bench for pc_ctrl with default RESET_PC/EXC_VECTOR.
module tb_pc_ctrl;

    logic        clk = 1'b0;
    logic        rst, stall, ivld, halt, ill, rti, jmp, rvld;
    logic [15:0] jdisp, rtgt;
    logic [15:0] pc_p1, pc_ifid_p1, epc_p1;
    logic        fetch_en_p1, flush_ifid_p1, in_exc_p1;
    logic [1:0]  state_p1;
    int          passed = 0;
    int          total  = 0;

    always #5 clk = ~clk;

    pc_ctrl dut (
        .clk                            (clk),
        .rst                            (rst),
        .stall_p1                       (stall),
        .inst_valid_idif_p1             (ivld),
        .halt_idif_p1                   (halt),
        .illegal_op_idif_p1             (ill),
        .return_execution_idif_p1       (rti),
        .jmp_displacement_idif_p1       (jmp),
        .jmp_displacement_value_idif_p1 (jdisp),
        .redirect_valid_ixif_p1         (rvld),
        .redirect_target_ixif_p1        (rtgt),
        .pc_p1                          (pc_p1),
        .pc_ifid_p1                     (pc_ifid_p1),
        .epc_p1                         (epc_p1),
        .fetch_en_p1                    (fetch_en_p1),
        .flush_ifid_p1                  (flush_ifid_p1),
        .in_exc_p1                      (in_exc_p1),
        .state_p1                       (state_p1)
    );

    task automatic idle();
        stall = 0; ivld = 0; halt = 0; ill = 0; rti = 0; jmp = 0; rvld = 0;
        jdisp = '0; rtgt = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic redir(input logic [15:0] t);
        rvld = 1; rtgt = t;
        step();
        idle();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #2;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        #2;
        total++; if (pc_p1 !== 16'h0000) $display("FAIL rst_pc got %h exp 0000", pc_p1); else passed++;
        total++; if (pc_ifid_p1 !== 16'h0000) $display("FAIL rst_pc_ifid got %h exp 0000", pc_ifid_p1); else passed++;
        total++; if ({epc_p1, in_exc_p1, state_p1} !== 19'h0) $display("FAIL rst_epc_exc_state got %h/%b/%b exp 0/0/00", epc_p1, in_exc_p1, state_p1); else passed++;
        total++; if ({fetch_en_p1, flush_ifid_p1} !== 2'b11) $display("FAIL rst_fetch_flush got %b%b exp 11", fetch_en_p1, flush_ifid_p1); else passed++;
        @(negedge clk);
        rst = 1'b0;
        #1;
        total++; if ({pc_p1, flush_ifid_p1} !== {16'h0000, 1'b1}) $display("FAIL rel_c0 got %h/%b exp 0000/1", pc_p1, flush_ifid_p1); else passed++;
    endtask

    task automatic test_sequential();
        for (int k = 1; k <= 4; k++) begin
            step();
            total++;
            if ({pc_p1, pc_ifid_p1, flush_ifid_p1} !== {16'(2 * k), 16'(2 * k - 2), 1'b0})
                $display("FAIL seq_%0d got %h/%h/%b exp %h/%h/0", k, pc_p1, pc_ifid_p1, flush_ifid_p1, 16'(2 * k), 16'(2 * k - 2));
            else passed++;
        end
    endtask

    task automatic test_jmp();
        redir(16'h0010);
        total++; if ({pc_p1, flush_ifid_p1} !== {16'h0010, 1'b1}) $display("FAIL redir_pc got %h/%b exp 0010/1", pc_p1, flush_ifid_p1); else passed++;
        ivld = 1; jmp = 1; jdisp = 16'hFFF0;   // wrong-path J must be dropped
        step();
        idle();
        total++; if ({pc_p1, pc_ifid_p1} !== {16'h0012, 16'h0010}) $display("FAIL jmp_flushed got %h/%h exp 0012/0010", pc_p1, pc_ifid_p1); else passed++;
        ivld = 1; jmp = 1; jdisp = 16'hFFF0;
        step();
        idle();
        total++; if ({pc_p1, flush_ifid_p1} !== {16'h0002, 1'b1}) $display("FAIL jmp_back got %h/%b exp 0002/1", pc_p1, flush_ifid_p1); else passed++;
        step();
        total++; if (flush_ifid_p1 !== 1'b0) $display("FAIL jmp_flush_1cyc got %b exp 0", flush_ifid_p1); else passed++;
        redir(16'hFFFE);
        step();
        total++; if ({pc_p1, pc_ifid_p1} !== {16'h0000, 16'hFFFE}) $display("FAIL seq_wrap got %h/%h exp 0000/fffe", pc_p1, pc_ifid_p1); else passed++;
        ivld = 1; jmp = 1; jdisp = 16'h0000;
        step();
        idle();
        total++; if ({pc_p1, flush_ifid_p1} !== {16'h0000, 1'b1}) $display("FAIL jmp_wrap got %h/%b exp 0000/1", pc_p1, flush_ifid_p1); else passed++;
    endtask

    task automatic test_illegal();
        redir(16'h0040);
        step();
        ivld = 1; ill = 1;
        step();
        idle();
        total++; if ({epc_p1, in_exc_p1, state_p1} !== {16'h0042, 1'b1, 2'b01}) $display("FAIL ill_enter got %h/%b/%b exp 0042/1/01", epc_p1, in_exc_p1, state_p1); else passed++;
        total++; if ({fetch_en_p1, flush_ifid_p1} !== 2'b01) $display("FAIL ill_fetch_flush got %b%b exp 01", fetch_en_p1, flush_ifid_p1); else passed++;
        step();
        total++; if ({pc_p1, fetch_en_p1, state_p1} !== {16'h0002, 1'b1, 2'b00}) $display("FAIL exc_vector got %h/%b/%b exp 0002/1/00", pc_p1, fetch_en_p1, state_p1); else passed++;
        step();
        ivld = 1; rti = 1;
        step();
        idle();
        total++; if ({pc_p1, in_exc_p1, flush_ifid_p1} !== {16'h0042, 1'b0, 1'b1}) $display("FAIL rti got %h/%b/%b exp 0042/0/1", pc_p1, in_exc_p1, flush_ifid_p1); else passed++;
        step();
        ivld = 1; rti = 1;
        step();
        idle();
        total++; if ({pc_p1, in_exc_p1} !== {16'h0042, 1'b0}) $display("FAIL rti_noexc got %h/%b exp 0042/0", pc_p1, in_exc_p1); else passed++;
    endtask

    task automatic test_stall();
        redir(16'h0100);
        stall = 1;
        #1;
        total++; if (flush_ifid_p1 !== 1'b0) $display("FAIL stall_flush_mask got %b exp 0", flush_ifid_p1); else passed++;
        stall = 0;
        step();
        stall = 1; ivld = 1; jmp = 1; jdisp = 16'h0010; rvld = 1; rtgt = 16'h0BAD;
        for (int k = 0; k < 3; k++) begin
            step();
            total++;
            if ({pc_p1, pc_ifid_p1, flush_ifid_p1, state_p1, fetch_en_p1} !== {16'h0102, 16'h0100, 1'b0, 2'b00, 1'b1})
                $display("FAIL stall_hold_%0d got %h/%h/%b/%b exp 0102/0100/0/00", k, pc_p1, pc_ifid_p1, flush_ifid_p1, state_p1);
            else passed++;
        end
        stall = 0; rvld = 0;
        step();
        idle();
        total++; if ({pc_p1, flush_ifid_p1} !== {16'h0112, 1'b1}) $display("FAIL stall_jmp got %h/%b exp 0112/1", pc_p1, flush_ifid_p1); else passed++;
    endtask

    task automatic test_redirect_halt();
        step();
        rvld = 1; rtgt = 16'h0100; ivld = 1; halt = 1;
        step();
        idle();
        total++; if ({pc_p1, state_p1} !== {16'h0100, 2'b00}) $display("FAIL redir_over_halt got %h/%b exp 0100/00", pc_p1, state_p1); else passed++;
        step();
        ivld = 1; halt = 1;
        step();
        idle();
        total++; if ({state_p1, fetch_en_p1, pc_p1} !== {2'b10, 1'b0, 16'h0102}) $display("FAIL halt got %b/%b/%h exp 10/0/0102", state_p1, fetch_en_p1, pc_p1); else passed++;
        rvld = 1; rtgt = 16'h0200;
        step(); step(); step();
        idle();
        total++; if ({state_p1, fetch_en_p1, pc_p1} !== {2'b10, 1'b0, 16'h0102}) $display("FAIL halt_sticky got %b/%b/%h exp 10/0/0102", state_p1, fetch_en_p1, pc_p1); else passed++;
        do_reset();
        total++; if ({state_p1, fetch_en_p1, epc_p1, pc_p1} !== {2'b00, 1'b1, 16'h0000, 16'h0000}) $display("FAIL halt_rst got %b/%b/%h/%h exp 00/1/0000/0000", state_p1, fetch_en_p1, epc_p1, pc_p1); else passed++;
    endtask

    task automatic test_nested();
        redir(16'h0040);
        step();
        ivld = 1; ill = 1;
        step();
        idle();
        step();
        step();
        total++; if ({pc_p1, pc_ifid_p1, in_exc_p1} !== {16'h0004, 16'h0002, 1'b1}) $display("FAIL handler_pc got %h/%h/%b exp 0004/0002/1", pc_p1, pc_ifid_p1, in_exc_p1); else passed++;
        ivld = 1; ill = 1;
        step();
        idle();
`ifdef PC_CTRL_DFAULT_EN
        total++; if ({state_p1, fetch_en_p1, epc_p1} !== {2'b10, 1'b0, 16'h0042}) $display("FAIL dfault got %b/%b/%h exp 10/0/0042", state_p1, fetch_en_p1, epc_p1); else passed++;
`else
        total++; if ({state_p1, fetch_en_p1, epc_p1} !== {2'b01, 1'b0, 16'h0004}) $display("FAIL nested_ill got %b/%b/%h exp 01/0/0004", state_p1, fetch_en_p1, epc_p1); else passed++;
`endif
        do_reset();
        total++; if ({state_p1, in_exc_p1, epc_p1, fetch_en_p1} !== {2'b00, 1'b0, 16'h0000, 1'b1}) $display("FAIL exc_rst got %b/%b/%h/%b exp 00/0/0000/1", state_p1, in_exc_p1, epc_p1, fetch_en_p1); else passed++;
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_jmp();
        test_illegal();
        test_stall();
        test_redirect_halt();
        test_nested();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
